rtc_bus_ctrl: RTL and testbench

- Downstream stage of the menu/sequencer FSM; executes the physical bus cycle to the external RTC over its multiplexed address/data bus (CS_n, RD_n, WR_n, A_D, AD[7:0]).
- Consumes Acceso (start), Mod (1 = write, 0 = read), Dir and write data; returns read data and a one-cycle FRW completion pulse.
- After reset, autonomously runs a fixed RTC initialisation sequence, then pulses FRW to release the sequencer.

---
 rtl/rtc_bus_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_ctrl.sv
// rtl/rtc_bus_ctrl.sv - RTC multiplexed address/data bus cycle engine
//
// Runs one physical read or write cycle on the external RTC bus for each
// rising edge of Acceso seen while idle. Out of reset it first writes 8'h10
// and then 8'h00 to RTC register 8'h02. It then pulses FRW once to release
// the upstream sequencer.
//
// Optional feature macro: RTC_BCD_CHECK_EN (BCD sanity check on time/date reads).
//
// Ports:
//   CLK, RST            clock, synchronous active-low reset
//   Acceso              transaction request (rising edge starts a cycle)
//   Mod, Dir, Dato_wr   1=write/0=read, register address, write data (sampled at start)
//   Dato_rd             last byte read from the RTC
//   FRW                 one-cycle completion pulse (transaction or init sequence)
//   Ocupado             high whenever the engine is not idle
//   BCD_err             read-data BCD error flag (0 unless RTC_BCD_CHECK_EN)
//   CS_n, RD_n, WR_n    registered RTC strobes, active-low
//   A_D                 0 = address phase, 1 = data phase
//   AD                  multiplexed bus, driven only in address and write-data phases
module rtc_bus_ctrl #(
    parameter int unsigned T_PHASE = 4,
    parameter int unsigned T_GAP   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Acceso,
    input  logic       Mod,
    input  logic [7:0] Dir,
    input  logic [7:0] Dato_wr,
    output logic [7:0] Dato_rd,
    output logic       FRW,
    output logic       Ocupado,
    output logic       BCD_err,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       A_D,
    inout  wire  [7:0] AD
);

    typedef enum logic [2:0] {
        S_INIT_A, S_INIT_B, S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2, S_DONE
    } state_e;

    // Which sequence the current ADDR..GAP2 pass belongs to.
    localparam logic [1:0] STEP_INIT_A = 2'd0;
    localparam logic [1:0] STEP_INIT_B = 2'd1;
    localparam logic [1:0] STEP_USER   = 2'd2;

    localparam logic [7:0] PH_LAST  = 8'(T_PHASE - 1);
    localparam logic [7:0] GAP_LAST = 8'(T_GAP - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] step_q, step_d;
    logic       acc_q;
    logic       mod_q, mod_d;
    logic [7:0] dir_q, dir_d;
    logic [7:0] wdat_q, wdat_d;
    logic [7:0] rd_q, rd_d;
    logic       start;

    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       a_d_q, a_d_d;
    logic       ad_oe_q, ad_oe_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       frw_q, frw_d;
    logic       ocup_q, ocup_d;

    assign start = Acceso & ~acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = 8'(cnt_q + 8'd1);
        step_d  = step_q;
        mod_d   = mod_q;
        dir_d   = dir_q;
        wdat_d  = wdat_q;
        rd_d    = rd_q;
        unique case (state_q)
            S_INIT_A: begin
                step_d  = STEP_INIT_A;
                mod_d   = 1'b1;
                dir_d   = 8'h02;
                wdat_d  = 8'h10;
                state_d = S_ADDR;
            end
            S_INIT_B: begin
                step_d  = STEP_INIT_B;
                mod_d   = 1'b1;
                dir_d   = 8'h02;
                wdat_d  = 8'h00;
                state_d = S_ADDR;
            end
            S_IDLE: begin
                if (start) begin
                    step_d  = STEP_USER;
                    mod_d   = Mod;
                    dir_d   = Dir;
                    wdat_d  = Dato_wr;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: if (cnt_q == PH_LAST) state_d = S_GAP1;
            S_GAP1: if (cnt_q == GAP_LAST) state_d = S_DATA;
            S_DATA: begin
                if (cnt_q == PH_LAST) begin
                    state_d = S_GAP2;
                    // RD_n has been low the whole phase; take the byte now.
                    if (!mod_q) rd_d = AD;
                end
            end
            S_GAP2: begin
                if (cnt_q == GAP_LAST)
                    state_d = (step_q == STEP_INIT_A) ? S_INIT_B : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_INIT_A;
        endcase
        if (state_d != state_q) cnt_d = 8'd0;

        // Pin values are decoded from the next state so they leave a flop
        // in the same cycle the state register enters that state.
        cs_n_d   = !(state_d == S_ADDR || state_d == S_DATA);
        wr_n_d   = !(state_d == S_ADDR || (state_d == S_DATA && mod_d));
        rd_n_d   = !(state_d == S_DATA && !mod_d);
        a_d_d    = (state_d == S_DATA);
        ad_oe_d  = (state_d == S_ADDR) || (state_d == S_DATA && mod_d);
        ad_out_d = (state_d == S_DATA) ? wdat_d : dir_d;
        frw_d    = (state_d == S_DONE);
        ocup_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= S_INIT_A;
            cnt_q    <= 8'd0;
            step_q   <= STEP_INIT_A;
            acc_q    <= 1'b0;
            mod_q    <= 1'b0;
            dir_q    <= 8'h00;
            wdat_q   <= 8'h00;
            rd_q     <= 8'h00;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            a_d_q    <= 1'b0;
            ad_oe_q  <= 1'b0;
            ad_out_q <= 8'h00;
            frw_q    <= 1'b0;
            ocup_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            acc_q    <= Acceso;
            mod_q    <= mod_d;
            dir_q    <= dir_d;
            wdat_q   <= wdat_d;
            rd_q     <= rd_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            a_d_q    <= a_d_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
            frw_q    <= frw_d;
            ocup_q   <= ocup_d;
        end
    end

`ifdef RTC_BCD_CHECK_EN
    // Seconds..year (8'h21-8'h26) and alarm (8'h41-8'h43) registers hold BCD.
    logic bcd_q, bcd_d, in_range, bad_nib;

    assign in_range = (dir_q >= 8'h21 && dir_q <= 8'h26) ||
                      (dir_q >= 8'h41 && dir_q <= 8'h43);
    assign bad_nib  = (rd_q[7:4] > 4'd9) || (rd_q[3:0] > 4'd9);

    always_comb begin
        bcd_d = bcd_q;
        // Update on the edge that raises FRW for a read; writes leave it alone.
        if (state_d == S_DONE && state_q != S_DONE && !mod_q)
            bcd_d = in_range && bad_nib;
    end

    always_ff @(posedge CLK) begin
        if (!RST) bcd_q <= 1'b0;
        else      bcd_q <= bcd_d;
    end

    assign BCD_err = bcd_q;
`else
    assign BCD_err = 1'b0;
`endif

    assign Dato_rd = rd_q;
    assign FRW     = frw_q;
    assign Ocupado = ocup_q;
    assign CS_n    = cs_n_q;
    assign RD_n    = rd_n_q;
    assign WR_n    = wr_n_q;
    assign A_D     = a_d_q;
    assign AD      = ad_oe_q ? ad_out_q : 8'bz;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb/tb_rtc_bus_ctrl.sv - scoreboard testbench for rtc_bus_ctrl
module tb_rtc_bus_ctrl;

    localparam int TP = 4;
    localparam int TG = 2;
    localparam int LAT = 1 + 2 * TP + 2 * TG + 1;
`ifdef RTC_BCD_CHECK_EN
    localparam logic EXP_BAD = 1'b1;
`else
    localparam logic EXP_BAD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST, Acceso, Mod;
    logic [7:0] Dir, Dato_wr;
    wire  [7:0] Dato_rd;
    wire        FRW, Ocupado, BCD_err, CS_n, RD_n, WR_n, A_D;
    wire  [7:0] AD;
    logic [7:0] rtc_data;

    always #5 CLK = ~CLK;

    // RTC model: drives the bus only while the controller reads.
    assign AD = (!RD_n) ? rtc_data : 8'bz;

    rtc_bus_ctrl #(.T_PHASE(TP), .T_GAP(TG)) dut (
        .CLK(CLK), .RST(RST), .Acceso(Acceso), .Mod(Mod), .Dir(Dir),
        .Dato_wr(Dato_wr), .Dato_rd(Dato_rd), .FRW(FRW), .Ocupado(Ocupado),
        .BCD_err(BCD_err), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
        .A_D(A_D), .AD(AD)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       wr;
        logic [7:0] dir;
        logic [7:0] data;
    } txn_t;

    txn_t exp_q[$];
    txn_t e;

    // Bus monitor: rebuilds each bus cycle and checks it against the scoreboard.
    int         addr_len = 0, data_len = 0, frw_cnt = 0, overlap = 0;
    logic [7:0] m_dir = 8'h00, m_data = 8'h00;
    logic       m_wr = 1'b0;

    always @(negedge CLK) begin
        if (!RST) begin
            addr_len = 0;
            data_len = 0;
        end else begin
            if (!RD_n && !WR_n) overlap++;
            if (FRW) frw_cnt++;
            if (!CS_n && !A_D) begin
                if (!WR_n && RD_n) addr_len++;
                m_dir = AD;
            end else if (!CS_n && A_D) begin
                if (!WR_n || !RD_n) data_len++;
                m_wr = !WR_n;
                if (!WR_n) m_data = AD;
            end else if (data_len > 0) begin
                check_eq("txn_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("txn_dir", m_dir, e.dir);
                    check_eq("txn_wr", m_wr, e.wr);
                    check_eq("txn_data", m_wr ? m_data : Dato_rd, e.data);
                    check_eq("addr_len", addr_len, TP);
                    check_eq("data_len", data_len, TP);
                end
                addr_len = 0;
                data_len = 0;
            end
        end
    end

    task automatic push(input logic wr, input logic [7:0] dir, input logic [7:0] data);
        txn_t t;
        t.wr = wr;
        t.dir = dir;
        t.data = data;
        exp_q.push_back(t);
    endtask

    task automatic wait_frw(input string tag);
        int n = 0;
        while (!FRW && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check_eq(tag, FRW, 1);
    endtask

    // Called just after a negedge; lat counts cycles inclusively from the
    // cycle Acceso is raised to the cycle FRW is high.
    task automatic run_txn(input logic m, input logic [7:0] d, input logic [7:0] w, input string tag);
        int lat = 1;
        Mod = m; Dir = d; Dato_wr = w; Acceso = 1'b1;
        while (lat < 100) begin
            @(negedge CLK);
            lat++;
            if (FRW) break;
        end
        check_eq({tag, "_lat"}, lat, LAT);
        Acceso = 1'b0;
        @(negedge CLK);
        check_eq({tag, "_frw_pulse"}, FRW, 0);
        check_eq({tag, "_ocupado"}, Ocupado, 0);
    endtask

    initial begin
        int f0;
        int n;
        RST = 1'b0; Acceso = 1'b0; Mod = 1'b0; Dir = 8'h00; Dato_wr = 8'h00; rtc_data = 8'h00;
        repeat (3) @(negedge CLK);
        check_eq("rst_cs", CS_n, 1);
        check_eq("rst_rd", RD_n, 1);
        check_eq("rst_wr", WR_n, 1);
        check_eq("rst_ad", A_D, 0);
        check_eq("rst_frw", FRW, 0);
        check_eq("rst_ocup", Ocupado, 1);
        check_eq("rst_dato", Dato_rd, 8'h00);
        check_eq("rst_bcd", BCD_err, 0);

        push(1'b1, 8'h02, 8'h10);
        push(1'b1, 8'h02, 8'h00);
        RST = 1'b1;
        wait_frw("init_frw");
        @(negedge CLK);
        check_eq("init_frw_pulse", FRW, 0);
        check_eq("init_ocup_low", Ocupado, 0);
        repeat (2) @(negedge CLK);
        check_eq("init_frw_count", frw_cnt, 1);
        check_eq("init_queue_empty", exp_q.size(), 0);

        rtc_data = 8'h59;
        push(1'b0, 8'h23, 8'h59);
        run_txn(1'b0, 8'h23, 8'h00, "read");
        check_eq("read_dato", Dato_rd, 8'h59);
        check_eq("read_bcd", BCD_err, 0);

        push(1'b1, 8'hF0, 8'hA5);
        run_txn(1'b1, 8'hF0, 8'hA5, "write");

        // Second rising edge three cycles into ADDR must be dropped.
        f0 = frw_cnt;
        push(1'b1, 8'h11, 8'h22);
        Mod = 1'b1; Dir = 8'h11; Dato_wr = 8'h22; Acceso = 1'b1;
        repeat (3) @(negedge CLK);
        Acceso = 1'b0;
        @(negedge CLK);
        Acceso = 1'b1;
        @(negedge CLK);
        Acceso = 1'b0;
        repeat (25) @(negedge CLK);
        check_eq("retrig_frw_count", frw_cnt - f0, 1);
        check_eq("retrig_queue", exp_q.size(), 0);

        // Level held past the end of the cycle must not restart it.
        f0 = frw_cnt;
        rtc_data = 8'h17;
        push(1'b0, 8'h42, 8'h17);
        Mod = 1'b0; Dir = 8'h42; Acceso = 1'b1;
        repeat (20) @(negedge CLK);
        Acceso = 1'b0;
        repeat (5) @(negedge CLK);
        check_eq("held_frw_count", frw_cnt - f0, 1);
        check_eq("held_queue", exp_q.size(), 0);

        // Reset during the data phase of a write.
        Mod = 1'b1; Dir = 8'h55; Dato_wr = 8'h66; Acceso = 1'b1;
        n = 0;
        while (!(!CS_n && A_D) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check_eq("mid_data_reached", !CS_n && A_D, 1);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("mid_rst_cs", CS_n, 1);
        check_eq("mid_rst_wr", WR_n, 1);
        check_eq("mid_rst_ad", A_D, 0);
        check_eq("mid_rst_frw", FRW, 0);
        check_eq("mid_rst_ocup", Ocupado, 1);
        Acceso = 1'b0;
        @(negedge CLK);
        f0 = frw_cnt;
        push(1'b1, 8'h02, 8'h10);
        push(1'b1, 8'h02, 8'h00);
        RST = 1'b1;
        wait_frw("reinit_frw");
        repeat (3) @(negedge CLK);
        check_eq("reinit_frw_count", frw_cnt - f0, 1);
        check_eq("reinit_queue", exp_q.size(), 0);

        // BCD flag: bad read, unaffected by a write, cleared by a good read.
        rtc_data = 8'h7A;
        push(1'b0, 8'h22, 8'h7A);
        run_txn(1'b0, 8'h22, 8'h00, "bcd_bad");
        check_eq("bcd_set", BCD_err, EXP_BAD);
        push(1'b1, 8'h30, 8'h12);
        run_txn(1'b1, 8'h30, 8'h12, "bcd_wr");
        check_eq("bcd_hold", BCD_err, EXP_BAD);
        rtc_data = 8'h45;
        push(1'b0, 8'h22, 8'h45);
        run_txn(1'b0, 8'h22, 8'h00, "bcd_good");
        check_eq("bcd_clear", BCD_err, 0);

        repeat (3) @(negedge CLK);
        check_eq("strobe_overlap", overlap, 0);
        check_eq("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
